// File: rtl/block_mem_responder.sv
// ============================================================================
// Module   : block_mem_responder
// Brief    : Fixed-latency block memory responder for the cache-to-memory port.
//            Optional BLOCK_MEM_BYTE_SWAP_EN stores each 32-bit word byte-reversed.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module block_mem_responder #(
    parameter int ADDR_W  = 28,
    parameter int DEPTH   = 64,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [127:0]      mem_wdata,
    output logic [127:0]      mem_rdata,
    output logic              mem_ready,
    output logic              mem_err
);

    localparam int         IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0] CNT_LOAD  = 8'(LATENCY - 1);
    localparam logic       LAT_ONE   = (LATENCY == 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q;
    logic [7:0]          cnt_q;
    logic                write_q;
    logic                both_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [127:0]        wdata_q;
    logic                ready_q;
    logic                err_q;
    logic [127:0]        rdata_q;

    // Zero at time 0 and deliberately untouched by reset.
    logic [127:0]        mem_q [DEPTH] = '{default: '0};

    logic                enter_resp_d;
    logic                sel_write_d;
    logic                sel_both_d;
    logic [ADDR_W-1:0]   sel_addr_d;
    logic [127:0]        sel_wdata_d;
    logic                in_range_d;
    logic [IDX_W-1:0]    idx_d;

    function automatic logic [127:0] f_swap(input logic [127:0] d);
        logic [127:0] r;
`ifdef BLOCK_MEM_BYTE_SWAP_EN
        for (int w = 0; w < 4; w++) begin
            for (int b = 0; b < 4; b++) begin
                r[w*32 + b*8 +: 8] = d[w*32 + (3-b)*8 +: 8];
            end
        end
`else
        r = d;
`endif
        return r;
    endfunction

    // With LATENCY=1 the RESP-entry edge is the sampling edge, so the live
    // request inputs stand in for the not-yet-latched copies.
    always_comb begin
        enter_resp_d = 1'b0;
        sel_write_d  = write_q;
        sel_both_d   = both_q;
        sel_addr_d   = addr_q;
        sel_wdata_d  = wdata_q;
        if (LAT_ONE && state_q == IDLE && (mem_read || mem_write)) begin
            enter_resp_d = 1'b1;
            sel_write_d  = mem_write;
            sel_both_d   = mem_read & mem_write;
            sel_addr_d   = mem_addr;
            sel_wdata_d  = mem_wdata;
        end else if (state_q == WAIT && cnt_q == 8'd1) begin
            enter_resp_d = 1'b1;
        end
        in_range_d = (sel_addr_d < ADDR_W'(DEPTH));
        idx_d      = sel_addr_d[IDX_W-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            write_q <= 1'b0;
            both_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mem_read || mem_write) begin
                        write_q <= mem_write;
                        both_q  <= mem_read & mem_write;
                        addr_q  <= mem_addr;
                        wdata_q <= mem_wdata;
                        cnt_q   <= CNT_LOAD;
                        state_q <= LAT_ONE ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_q <= RESP;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
            if (enter_resp_d) begin
                ready_q <= 1'b1;
                err_q   <= sel_both_d | ~in_range_d;
                if (!sel_write_d) begin
                    rdata_q <= in_range_d ? f_swap(mem_q[idx_d]) : 128'd0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst && enter_resp_d && sel_write_d && in_range_d) begin
            mem_q[idx_d] <= f_swap(sel_wdata_d);
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_ready = ready_q;
    assign mem_err   = err_q;

endmodule

`default_nettype wire

// File: doc/block_mem_responder.md
# block_mem_responder

Cycle-accurate slow-memory responder that models the off-chip memory behind the instruction/data caches. It answers block-granular read and write requests from a cache controller with a fixed, parameterised latency and a one-cycle ready pulse, and holds the memory image the test bench checks after the program finishes. It sits between the cache miss/write-back path and the bench, as the memory-side end of the cache-to-memory interface.

## Interface
- ADDR_W, 28, block address width (one address = one 128-bit block = four 32-bit words)
- DEPTH, 64, number of blocks stored; valid addresses 0..DEPTH-1
- LATENCY, 4, cycles from request sampling edge to ready pulse; legal range 1..255
- clk  input  1  clock; all state updates on posedge
- rst  input  1  reset; one clock, asynchronous, active-low (clears when rst=0)
- mem_read  input  1  read request, held high until mem_ready observed
- mem_write  input  1  write request, held high until mem_ready observed
- mem_addr  input  ADDR_W  block address, stable while request held
- mem_wdata  input  128  write block, word 0 in bits [31:0]
- mem_rdata  output  128  read block, valid in the mem_ready cycle of a read, held until next read response
- mem_ready  output  1  one-cycle completion pulse
- mem_err  output  1  one-cycle pulse coincident with mem_ready on a faulted request

## Operation
- FSM states IDLE, WAIT, RESP. Reset state IDLE.
- IDLE: on posedge with mem_read|mem_write=1, latch op, mem_addr, mem_wdata; load cnt=LATENCY-1; go WAIT if LATENCY>1, else RESP.
- WAIT: cnt decrements each cycle; when cnt==1 at posedge go RESP. Inputs ignored; latched values used.
- RESP: mem_ready=1 for exactly this cycle. Read: mem_rdata=mem[addr] (registered on the RESP-entry edge). Write: mem[addr]<=wdata on the RESP-entry edge. Next state IDLE unconditionally.
- Requester drops request on the edge ending the RESP cycle; a request still high when IDLE samples is a new request (back-to-back allowed, minimum 1 IDLE cycle between transactions).
- mem_read and mem_write both high at sampling: write performed, read ignored, mem_err pulses with mem_ready.
- addr >= DEPTH: read returns 128'd0, write dropped, mem_err pulses with mem_ready.
- Outputs registered. Reset values: mem_ready=0, mem_err=0, mem_rdata=0, state IDLE, cnt=0.
- Memory array not cleared by rst; initialised to zero at time 0. Reset mid-transaction aborts it: no ready, no array write.
- cnt is 8 bits; no wrap occurs within legal LATENCY.

## Timing
- Request sampled at edge T (state IDLE) -> mem_ready high in the cycle after edge T+LATENCY-1, i.e. LATENCY cycles of occupancy including RESP.
- Throughput: one transaction per LATENCY+1 cycles with continuous requests.
- Write data visible to a following read of the same address (no hazard window).
- rst low asynchronously forces mem_ready=0, mem_err=0 within the same cycle.

## Configuration
- BLOCK_MEM_BYTE_SWAP_EN defined: each 32-bit word byte-reversed on write into the array and on read out ({b0,b1,b2,b3}), so the stored image is readable big-endian while the interface stays little-endian; array dump matches golden .dat files directly.
- Undefined: words stored and returned unmodified.
- Timing, FSM, and error behaviour identical in both builds.

## Test plan
- LATENCY=4: write addr 5 data 128'h0000000400000003_0000000200000001, then read addr 5 -> mem_ready exactly 4 cycles after each sample edge, mem_rdata equals written block, mem_err=0.
- Requests held through RESP back-to-back: read addr 0 then read addr 1 -> two ready pulses 5 cycles apart, no duplicate response.
- mem_read=mem_write=1, addr 2, wdata all 1s -> mem_err=1 with mem_ready; subsequent read of addr 2 returns all 1s.
- Read addr 64 (DEPTH=64) -> mem_rdata=0, mem_err=1; write addr 70 -> array unchanged, mem_err=1.
- Write addr 3 started, rst pulled low in WAIT -> mem_ready stays 0, outputs 0 immediately; read addr 3 after reset returns prior contents (0).
- BLOCK_MEM_BYTE_SWAP_EN defined, write word 32'h11223344 -> internal array word 32'h44332211, read back returns 32'h11223344; LATENCY=1 build gives ready one cycle after sampling.
